// File: rtl/l15_msg1_queue.sv
// L1.5 -> L2 msg1 request queue: captures non-empty beats, optionally drops
// repeats of a held beat, and presents entries in order over valid/ready.
`ifndef MSG_WIDTH
`define MSG_WIDTH 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 64
`endif
`ifndef TAG_WIDTH
`define TAG_WIDTH 8
`endif
`ifndef OWNER_BITS
`define OWNER_BITS 6
`endif
`ifndef MSG_TYPE_EMPTY
`define MSG_TYPE_EMPTY 8'd0
`endif

module l15_msg1_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2,
  parameter bit          DEDUP = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [`MSG_WIDTH-1:0]  in_type,
  input  logic [`DATA_WIDTH-1:0] in_data,
  input  logic [`TAG_WIDTH-1:0]  in_tag,
  input  logic [`OWNER_BITS-1:0] in_source,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [`MSG_WIDTH-1:0]  out_type,
  output logic [`DATA_WIDTH-1:0] out_data,
  output logic [`TAG_WIDTH-1:0]  out_tag,
  output logic [`OWNER_BITS-1:0] out_source,
  output logic [PTR_W:0]         count,
  output logic                   full,
  output logic                   overflow,
  output logic [7:0]             drop_cnt
);

  localparam int unsigned MSG_W  = `MSG_WIDTH;
  localparam int unsigned DATA_W = `DATA_WIDTH;
  localparam int unsigned TAG_W  = `TAG_WIDTH;
  localparam int unsigned SRC_W  = `OWNER_BITS;
  localparam int unsigned CNT_W  = PTR_W + 1;

  typedef struct packed {
    logic [MSG_W-1:0]  mtype;
    logic [DATA_W-1:0] data;
    logic [TAG_W-1:0]  tag;
    logic [SRC_W-1:0]  source;
  } msg_t;

  msg_t             mem [DEPTH];
  msg_t             in_msg;
  msg_t             prev_msg;
  msg_t             empty_msg;
  msg_t             head;
  logic             prev_vld;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             beat_vld;
  logic             is_repeat;
  logic             deq;
  logic             enq;
  logic             drop;

  assign in_msg    = '{mtype: in_type, data: in_data, tag: in_tag, source: in_source};
  assign empty_msg = '{mtype: MSG_W'(`MSG_TYPE_EMPTY), data: '0, tag: '0, source: '0};

  // Beat classification and handshake decisions
  assign beat_vld  = (in_type != MSG_W'(`MSG_TYPE_EMPTY));
  assign is_repeat = DEDUP && prev_vld && (in_msg == prev_msg);
  assign deq       = out_valid && out_ready;
  assign enq       = beat_vld && !is_repeat && (!full || deq);
  assign drop      = beat_vld && !is_repeat && full && !deq;

  // Pointers, occupancy, previous-beat tracking and overflow bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      prev_vld <= 1'b0;
      prev_msg <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      prev_vld <= beat_vld;
      prev_msg <= in_msg;
      if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
      if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
      if (enq && !deq)      count <= count + CNT_W'(1);
      else if (deq && !enq) count <= count - CNT_W'(1);
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

  // Entry storage; when full with a dequeue, the write reuses the slot being freed
  always_ff @(posedge clk) begin
    if (enq) mem[wr_ptr] <= in_msg;
  end

  assign out_valid  = (count != '0);
  assign full       = (count == CNT_W'(DEPTH));
  assign head       = out_valid ? mem[rd_ptr] : empty_msg;
  assign out_type   = head.mtype;
  assign out_data   = head.data;
  assign out_tag    = head.tag;
  assign out_source = head.source;

endmodule

// File: tb/tb_l15_msg1_queue.sv
// Randomized and directed bench for l15_msg1_queue; runs DEDUP=1 and DEDUP=0
// instances side by side against a queue-based reference model.
`timescale 1ns/1ps
`ifndef MSG_WIDTH
`define MSG_WIDTH 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 64
`endif
`ifndef TAG_WIDTH
`define TAG_WIDTH 8
`endif
`ifndef OWNER_BITS
`define OWNER_BITS 6
`endif

module tb_l15_msg1_queue;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [7:0]  t;
    logic [63:0] d;
    logic [7:0]  g;
    logic [5:0]  s;
  } beat_t;

  logic        clk;
  logic        rst_n;
  logic [7:0]  in_type;
  logic [63:0] in_data;
  logic [7:0]  in_tag;
  logic [5:0]  in_source;
  logic        out_ready;

  logic [1:0]       ov;
  logic [1:0][7:0]  otype;
  logic [1:0][63:0] odata;
  logic [1:0][7:0]  otag;
  logic [1:0][5:0]  osrc;
  logic [1:0][2:0]  ocnt;
  logic [1:0]       ofull;
  logic [1:0]       oovf;
  logic [1:0][7:0]  odrop;

  int checks;
  int failures;

  // Reference model state, index 0 = DEDUP=1, index 1 = DEDUP=0
  beat_t mq [2][$];
  beat_t mprev [2];
  bit    mpvld [2];
  bit    movf [2];
  int    mdrop [2];

  l15_msg1_queue #(.DEPTH(4), .PTR_W(2), .DEDUP(1'b1)) dut_d (
    .clk(clk), .rst_n(rst_n), .in_type(in_type), .in_data(in_data),
    .in_tag(in_tag), .in_source(in_source), .out_valid(ov[0]),
    .out_ready(out_ready), .out_type(otype[0]), .out_data(odata[0]),
    .out_tag(otag[0]), .out_source(osrc[0]), .count(ocnt[0]),
    .full(ofull[0]), .overflow(oovf[0]), .drop_cnt(odrop[0]));

  l15_msg1_queue #(.DEPTH(4), .PTR_W(2), .DEDUP(1'b0)) dut_n (
    .clk(clk), .rst_n(rst_n), .in_type(in_type), .in_data(in_data),
    .in_tag(in_tag), .in_source(in_source), .out_valid(ov[1]),
    .out_ready(out_ready), .out_type(otype[1]), .out_data(odata[1]),
    .out_tag(otag[1]), .out_source(osrc[1]), .count(ocnt[1]),
    .full(ofull[1]), .overflow(oovf[1]), .drop_cnt(odrop[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      mq[m].delete();
      mpvld[m] = 1'b0;
      mprev[m] = '0;
      movf[m]  = 1'b0;
      mdrop[m] = 0;
    end
  endtask

  task automatic model_step(input int m, input bit dedup);
    beat_t b;
    bit vld, rpt, deq, space;
    b     = '{t: in_type, d: in_data, g: in_tag, s: in_source};
    vld   = (b.t != 8'd0);
    rpt   = dedup && mpvld[m] && (b == mprev[m]);
    deq   = (mq[m].size() > 0) && out_ready;
    space = (mq[m].size() < DEPTH) || deq;
    if (deq) void'(mq[m].pop_front());
    if (vld && !rpt) begin
      if (space) mq[m].push_back(b);
      else begin
        movf[m] = 1'b1;
        if (mdrop[m] < 255) mdrop[m]++;
      end
    end
    mprev[m] = b;
    mpvld[m] = vld;
  endtask

  always @(posedge clk) begin
    if (rst_n) begin
      model_step(0, 1'b1);
      model_step(1, 1'b0);
    end
  end

  task automatic check_all();
    beat_t h;
    for (int m = 0; m < 2; m++) begin
      h = (mq[m].size() > 0) ? mq[m][0] : beat_t'(0);
      check($sformatf("m%0d_valid", m), 64'(ov[m]), 64'(mq[m].size() > 0));
      check($sformatf("m%0d_type", m), 64'(otype[m]), 64'(h.t));
      check($sformatf("m%0d_data", m), odata[m], h.d);
      check($sformatf("m%0d_tag", m), 64'(otag[m]), 64'(h.g));
      check($sformatf("m%0d_src", m), 64'(osrc[m]), 64'(h.s));
      check($sformatf("m%0d_count", m), 64'(ocnt[m]), 64'(mq[m].size()));
      check($sformatf("m%0d_full", m), 64'(ofull[m]), 64'(mq[m].size() == DEPTH));
      check($sformatf("m%0d_ovf", m), 64'(oovf[m]), 64'(movf[m]));
      check($sformatf("m%0d_drop", m), 64'(odrop[m]), 64'(mdrop[m]));
    end
  endtask

  task automatic drive(input beat_t b, input logic rdy);
    in_type   = b.t;
    in_data   = b.d;
    in_tag    = b.g;
    in_source = b.s;
    out_ready = rdy;
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  function automatic beat_t mk(input int t, input longint d, input int g, input int s);
    return '{t: 8'(t), d: 64'(d), g: 8'(g), s: 6'(s)};
  endfunction

  beat_t cur;
  beat_t first;

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    drive(beat_t'(0), 1'b0);
    model_reset();
    @(negedge clk);
    check_all();
    rst_n = 1'b1;

    // Ordering through two pointer wraps, one-cycle latency
    for (int i = 0; i < 10; i++) begin
      cur = mk(1 + i % 3, $urandom, i % 8, i % 4);
      drive(cur, 1'b1);
      cycle();
      check("lat_tag", 64'(otag[0]), 64'(i % 8));
      drive(beat_t'(0), 1'b1);
      cycle();
    end

    // Held beat for 5 cycles, EMPTY, then the same beat again
    cur = mk(2, 64'hA5, 3, 2);
    for (int i = 0; i < 5; i++) begin
      drive(cur, 1'b0);
      cycle();
    end
    drive(beat_t'(0), 1'b0);
    cycle();
    drive(cur, 1'b0);
    cycle();
    drive(beat_t'(0), 1'b0);
    cycle();
    check("dedup_count", 64'(ocnt[0]), 64'd2);
    check("nodedup_count", 64'(ocnt[1]), 64'd4);
    check("nodedup_drop", 64'(odrop[1]), 64'd2);
    check("nodedup_ovf", 64'(oovf[1]), 64'd1);

    // Fill to DEPTH, then full with a simultaneous dequeue
    for (int i = 0; i < 2; i++) begin
      drive(mk(1, 100 + i, 10 + i, 1), 1'b0);
      cycle();
    end
    drive(mk(3, 200, 20, 3), 1'b1);
    cycle();
    check("fulldeq_count", 64'(ocnt[0]), 64'd4);
    check("fulldeq_ovf", 64'(oovf[0]), 64'd0);

    // Drain, then back-pressure toggling with two entries
    for (int i = 0; i < 4; i++) begin
      drive(beat_t'(0), 1'b1);
      cycle();
    end
    drive(mk(1, 64'h1111, 5, 1), 1'b0);
    cycle();
    drive(mk(2, 64'h2222, 6, 2), 1'b0);
    cycle();
    for (int i = 0; i < 5; i++) begin
      drive(beat_t'(0), logic'(i % 2));
      cycle();
    end
    check("bp_valid", 64'(ov[0]), 64'd0);
    check("bp_type", 64'(otype[0]), 64'd0);

    // Overflow saturation with 300 distinct dropped beats
    first = mk(1, 64'hBEEF, 1, 1);
    drive(first, 1'b0);
    cycle();
    for (int i = 0; i < 303; i++) begin
      drive(mk(1 + i % 3, 64'h1000 + i, i % 256, i % 64), 1'b0);
      cycle();
    end
    check("sat_drop", 64'(odrop[0]), 64'd255);
    check("sat_ovf", 64'(oovf[0]), 64'd1);
    check("sat_count", 64'(ocnt[0]), 64'd4);
    check("sat_head", odata[0], 64'hBEEF);

    // Asynchronous reset mid-operation with 3 entries and overflow set
    drive(beat_t'(0), 1'b1);
    cycle();
    drive(beat_t'(0), 1'b0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    check("rst_count", 64'(ocnt[0]), 64'd0);
    check("rst_ovf", 64'(oovf[0]), 64'd0);
    #1;
    rst_n = 1'b1;
    drive(mk(2, 64'h77, 9, 5), 1'b0);
    cycle();
    check("rst_next_valid", 64'(ov[0]), 64'd1);
    check("rst_next_data", odata[0], 64'h77);

    // Randomized traffic with held beats and random back-pressure
    cur = '0;
    for (int i = 0; i < 1200; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 25) cur = '0;
      else if (r < 60 && cur.t != 8'd0) cur = cur;
      else cur = mk($urandom_range(1, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      drive(cur, logic'($urandom_range(0, 99) < 45));
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
